spi_inemo_resp: RTL and testbench
=================================

# spi_inemo_resp

- Synthesizable SPI responder that models the iNEMO inertial sensor side of the link.
- It is driven by the SPI initiator inside the inertial interface: it decodes 16-bit read/write frames, holds a small configuration register bank, and serves yaw-rate samples through the OUTZ registers.
- It raises INT when a fresh sample is ready and asserts `setup_done` once the initiator has completed the sensor configuration writes.
- It is used on FPGA-level loopback builds and as the synthesizable counterpart of the behavioural sensor model in full-chip benches.

## Interface

Parameters:

- `WHO_AM_I_VAL`, default 8'h6A: read-only value returned at address 0x0F.

Ports:

- `clk` — input, 1 — system clock.
- `rst` — input, 1 — asynchronous, active-high reset.
- `SS_n` — input, 1 — active-low select from the initiator; asynchronous to `clk`.
- `SCLK` — input, 1 — serial clock; idles high.
- `MOSI` — input, 1 — serial data from the initiator, MSB first.
- `MISO` — output, 1 — serial data to the initiator, MSB first.
- `INT` — output, 1 — data-ready interrupt to the initiator.
- `smp_vld` — input, 1 — one-`clk` pulse: `yaw_in` holds a new sample.
- `yaw_in` — input, 16 — signed yaw-rate sample.
- `setup_done` — output, 1 — sticky; configuration writes are complete.

## Operation

**Input synchronization**
- `SS_n`, `SCLK` and `MOSI` each pass through a two-flop synchronizer. `SCLK` has an extra flop for edge detection.
- The SPI mode is idle-high `SCLK`: the initiator changes `MOSI` on `SCLK` fall, and the responder samples on `SCLK` rise.

**Frame format** (16 bits, MSB first)
- Bit 15: R/W, 1 = read.
- Bits 14:8: address.
- Bits 7:0: write data. For a read frame these 8 bits are don't-care on `MOSI`, and `MISO` returns the read data.

**Frame FSM**
- IDLE: synchronized `SS_n` is high. The bit counter is cleared. Next state is ACTIVE on synchronized `SS_n` fall.
- ACTIVE: each detected `SCLK` rise shifts `MOSI` into a 16-bit RX shift register and increments a 5-bit counter, saturating at 16.
- After the 8th rise, the addressed register is loaded into the 8-bit TX shift register. On each following `SCLK` fall, TX shifts left and its MSB drives `MISO`.
- When `SS_n` rises in ACTIVE, the state goes to IDLE:
  - count == 16 and write frame: commit the write to the addressed register.
  - count == 16 and read of 0x27: clear INT.
  - count < 16: abort; no write and no INT clear.
  - Rises beyond the 16th are ignored.

**Register map** (unlisted addresses read 8'h00; writes to them are dropped)
- 0x0D INT1_CTRL: RW. Bit 1 enables INT.
- 0x0F WHO_AM_I: read-only, returns `WHO_AM_I_VAL`.
- 0x11 CTRL2_G: RW.
- 0x15 CTRL7_G: RW.
- 0x26 OUTZ_L_G: read-only, `yaw[7:0]`.
- 0x27 OUTZ_H_G: read-only, `yaw[15:8]`.

**Sample path**
- On `smp_vld`, `yaw_in` is latched into a pending register and a pending flag is set.
- The pending value is copied into the OUTZ registers in the first cycle the FSM is in IDLE. The copy sets `dr_flag` and clears pending.
- OUTZ therefore never changes inside a frame.
- A second `smp_vld` before the copy overwrites pending: newest sample wins.

**Outputs**
- INT = `dr_flag` AND INT1_CTRL[1].
- If the INT clear (end of a 0x27 read) and the OUTZ copy occur in the same cycle, the set wins and `dr_flag` stays 1.
- `setup_done` sets once INT1_CTRL[1] == 1 and CTRL2_G != 0. It clears only on `rst`.

## Timing

**Reset values**
- Outputs: `MISO` = 0, INT = 0, `setup_done` = 0.
- Registers: all RW registers = 0, OUTZ = 0.
- State: FSM in IDLE, `dr_flag` = 0, pending = 0.

**Edge detection and MISO**
- Detection lag is 3 `clk` from a pin edge.
- The `SCLK` high and low phases must each be at least 8 `clk`.
- `MISO` updates at most 4 `clk` after `SCLK` fall, and is therefore stable before the next rise.
- `MISO` = 0 during the first 8 bits and whenever in IDLE. It returns to 0 within 4 `clk` of `SS_n` rise.

**Write and INT latency**
- A write commit is visible 4 `clk` after the `SS_n` rise.
- INT clear has the same latency as a write commit.
- INT set occurs 1 `clk` after the OUTZ copy.

**Asynchronous reset**
- `rst` asserted mid-frame returns all state to reset values immediately.
- A frame already in progress when `rst` deasserts is ignored until `SS_n` returns high.

## Test plan

1. **Reset / WHO_AM_I:** assert `rst`, then send read frame 16'h8F00 → `MISO` returns 8'h6A; INT = 0; `setup_done` = 0.
2. **Configuration sequence:**
   - Write 16'h0D02 → INT1_CTRL = 8'h02, `setup_done` still 0.
   - Write 16'h1150 → `setup_done` = 1 within 5 `clk` of `SS_n` rise.
   - Read 0x11 returns 8'h50.
3. **Sample and INT:**
   - After step 2, pulse `smp_vld` with `yaw_in` = 16'hF3A7 → INT = 1.
   - Read 0x26 returns 8'hA7 with INT still 1.
   - Read 0x27 returns 8'hF3, and INT = 0 after the frame.
4. **Mid-frame sample:**
   - Pulse `smp_vld` (16'h1234) during a 0x27 read of old data 16'hF3A7 → frame returns 8'hF3.
   - OUTZ = 16'h1234 after `SS_n` rise; INT remains 1 (set wins).
5. **Aborted frame:** raise `SS_n` after 12 bits of write 16'h1160 → CTRL2_G stays 8'h50.
6. **Unmapped and async reset:**
   - Write 16'h2055 and read 0x20 → returns 8'h00.
   - Assert `rst` after 10 bits of a frame → all outputs 0 and registers cleared.

Source files
------------

// File: rtl/spi_inemo_resp.sv
`default_nettype none
// ============================================================================
// Module      : spi_inemo_resp
// Description : SPI responder modelling the iNEMO inertial sensor. Decodes
//               16-bit read/write frames (idle-high SCLK, sample on rise,
//               shift on fall), holds a small configuration bank and serves
//               yaw-rate samples through OUTZ with a data-ready interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_inemo_resp #(
   parameter logic [7:0] WHO_AM_I_VAL = 8'h6A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic        smp_vld,
   input  logic [15:0] yaw_in,
   output logic        setup_done
);

   localparam logic [6:0] c_ADDR_INT1  = 7'h0D;
   localparam logic [6:0] c_ADDR_WHO   = 7'h0F;
   localparam logic [6:0] c_ADDR_CTRL2 = 7'h11;
   localparam logic [6:0] c_ADDR_CTRL7 = 7'h15;
   localparam logic [6:0] c_ADDR_OUTZL = 7'h26;
   localparam logic [6:0] c_ADDR_OUTZH = 7'h27;
   localparam logic [4:0] c_FRAME_BITS = 5'd16;
   localparam logic [4:0] c_ADDR_BITS  = 5'd8;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   // synchronizers
   logic        r_ss_s1, r_ss_s2, r_ss_s3;
   logic        r_sclk_s1, r_sclk_s2, r_sclk_s3;
   logic        r_mosi_s1, r_mosi_s2;

   // frame datapath
   logic [15:0] r_rx;
   logic [4:0]  r_cnt;
   logic [7:0]  r_tx;
   logic        r_miso;

   // register bank and sample path
   logic [7:0]  r_int1;
   logic [7:0]  r_ctrl2;
   logic [7:0]  r_ctrl7;
   logic [15:0] r_outz;
   logic [15:0] r_pend_val;
   logic        r_pend;
   logic        r_dr;
   logic        r_int;
   logic        r_setup;

   // combinational strobes
   logic        w_sclk_rise;
   logic        w_sclk_fall;
   logic        w_ss_fall;
   logic [15:0] w_rx_next;
   logic [7:0]  w_rd_data;
   logic        w_shift;
   logic        w_load_tx;
   logic        w_tx_shift;
   logic        w_end;
   logic        w_commit_wr;
   logic        w_int_clr;
   logic        w_copy;

   assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
   assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
   assign w_ss_fall   = r_ss_s3 & ~r_ss_s2;
   assign w_rx_next   = {r_rx[14:0], r_mosi_s2};

   // The select chain resets low so a frame already running when reset lifts
   // never shows a falling edge; it is ignored until SS_n has gone high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ss_s1   <= 1'b0;
         r_ss_s2   <= 1'b0;
         r_ss_s3   <= 1'b0;
         r_sclk_s1 <= 1'b1;
         r_sclk_s2 <= 1'b1;
         r_sclk_s3 <= 1'b1;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
      end else begin
         r_ss_s1   <= SS_n;
         r_ss_s2   <= r_ss_s1;
         r_ss_s3   <= r_ss_s2;
         r_sclk_s1 <= SCLK;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_s3 <= r_sclk_s2;
         r_mosi_s1 <= MOSI;
         r_mosi_s2 <= r_mosi_s1;
      end
   end

   // Frame state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state decode and per-cycle frame strobes.
   always_comb begin
      w_state_next = r_state;
      w_shift      = 1'b0;
      w_load_tx    = 1'b0;
      w_tx_shift   = 1'b0;
      w_end        = 1'b0;
      w_commit_wr  = 1'b0;
      w_int_clr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_ss_fall) w_state_next = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (r_ss_s2) begin
               w_state_next = S_IDLE;
               w_end        = 1'b1;
               if (r_cnt == c_FRAME_BITS) begin
                  if (!r_rx[15])                       w_commit_wr = 1'b1;
                  else if (r_rx[14:8] == c_ADDR_OUTZH) w_int_clr   = 1'b1;
               end
            end else begin
               if (w_sclk_rise && (r_cnt < c_FRAME_BITS)) begin
                  w_shift = 1'b1;
                  if (r_cnt == (c_ADDR_BITS - 5'd1)) w_load_tx = 1'b1;
               end
               if (w_sclk_fall && (r_cnt >= c_ADDR_BITS) && (r_cnt < c_FRAME_BITS))
                  w_tx_shift = 1'b1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Read mux addressed by the header as it completes on the 8th rise.
   always_comb begin
      w_rd_data = 8'h00;
      case (w_rx_next[6:0])
         c_ADDR_INT1:  w_rd_data = r_int1;
         c_ADDR_WHO:   w_rd_data = WHO_AM_I_VAL;
         c_ADDR_CTRL2: w_rd_data = r_ctrl2;
         c_ADDR_CTRL7: w_rd_data = r_ctrl7;
         c_ADDR_OUTZL: w_rd_data = r_outz[7:0];
         c_ADDR_OUTZH: w_rd_data = r_outz[15:8];
         default:      w_rd_data = 8'h00;
      endcase
   end

   // RX shift, bit counter, TX shift and MISO drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx   <= 16'h0000;
         r_cnt  <= 5'd0;
         r_tx   <= 8'h00;
         r_miso <= 1'b0;
      end else if (r_state == S_IDLE) begin
         r_rx   <= 16'h0000;
         r_cnt  <= 5'd0;
         r_tx   <= 8'h00;
         r_miso <= 1'b0;
      end else begin
         if (w_end) r_miso <= 1'b0;
         if (w_shift) begin
            r_rx  <= w_rx_next;
            r_cnt <= r_cnt + 5'd1;
         end
         if (w_load_tx) r_tx <= w_rd_data;
         if (w_tx_shift) begin
            r_miso <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
         end
      end
   end

   // Commit completed write frames; unmapped and read-only targets drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_int1  <= 8'h00;
         r_ctrl2 <= 8'h00;
         r_ctrl7 <= 8'h00;
      end else if (w_commit_wr) begin
         case (r_rx[14:8])
            c_ADDR_INT1:  r_int1  <= r_rx[7:0];
            c_ADDR_CTRL2: r_ctrl2 <= r_rx[7:0];
            c_ADDR_CTRL7: r_ctrl7 <= r_rx[7:0];
            default:      ;
         endcase
      end
   end

   // Copy pending sample on any edge that leaves the FSM in IDLE, so the
   // end-of-frame copy coincides with an OUTZ_H clear and the set wins.
   assign w_copy = r_pend & (w_state_next == S_IDLE);

   // Pending sample capture, OUTZ update and data-ready flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend_val <= 16'h0000;
         r_pend     <= 1'b0;
         r_outz     <= 16'h0000;
         r_dr       <= 1'b0;
      end else begin
         if (smp_vld) begin
            r_pend_val <= yaw_in;
            r_pend     <= 1'b1;
         end else if (w_copy) begin
            r_pend     <= 1'b0;
         end
         if (w_copy) r_outz <= r_pend_val;
         if (w_copy)         r_dr <= 1'b1;
         else if (w_int_clr) r_dr <= 1'b0;
      end
   end

   // Registered INT and sticky setup-complete flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_int   <= 1'b0;
         r_setup <= 1'b0;
      end else begin
         r_int   <= r_dr & r_int1[1];
         r_setup <= r_setup | (r_int1[1] & (r_ctrl2 != 8'h00));
      end
   end

   assign MISO       = r_miso;
   assign INT        = r_int;
   assign setup_done = r_setup;

endmodule
`default_nettype wire

// File: tb/tb_spi_inemo_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_inemo_resp
// Description : Scoreboard bench for spi_inemo_resp. Stimulus pushes the
//               expected value of every observation into a queue; a monitor
//               pops and compares whenever an observation is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_inemo_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic        INT;
   logic        smp_vld;
   logic [15:0] yaw_in;
   logic        setup_done;

   typedef struct {
      string       name;
      logic [15:0] val;
   } exp_t;

   exp_t        q[$];
   logic        obs_vld = 1'b0;
   logic [15:0] obs_data = 16'h0000;
   int          n_total = 0;
   int          n_bad   = 0;

   spi_inemo_resp #(.WHO_AM_I_VAL(8'h6A)) dut (
      .clk        (clk),
      .rst        (rst),
      .SS_n       (SS_n),
      .SCLK       (SCLK),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .INT        (INT),
      .smp_vld    (smp_vld),
      .yaw_in     (yaw_in),
      .setup_done (setup_done)
   );

   always #5 clk = ~clk;

   // Monitor: pop the oldest expectation whenever an observation appears.
   always @(negedge clk) begin
      if (obs_vld) begin
         n_total++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected: got %h, required no observation", obs_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (obs_data !== e.val) begin
               n_bad++;
               $display("FAIL %s: got %h, required %h", e.name, obs_data, e.val);
            end
         end
      end
   end

   task automatic push_exp(input string nm, input logic [15:0] v);
      exp_t e;
      e.name = nm;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic observe(input logic [15:0] v);
      @(posedge clk);
      obs_data = v;
      obs_vld  = 1'b1;
      @(posedge clk);
      obs_vld  = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [15:0] expv, input logic [15:0] act);
      push_exp(nm, expv);
      observe(act);
   endtask

   // Initiator model: MOSI changes on SCLK fall, MISO sampled just before rise.
   task automatic spi_xfer(input logic [15:0] f, input int nbits, input bit raise_ss,
                           input int pulse_bit, input logic [15:0] pulse_val,
                           output logic [7:0] rd);
      rd = 8'h00;
      @(negedge clk);
      SS_n = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = f[15-i];
         if (i == pulse_bit) begin
            smp_vld = 1'b1;
            yaw_in  = pulse_val;
            @(negedge clk);
            smp_vld = 1'b0;
            repeat (9) @(negedge clk);
         end else begin
            repeat (10) @(negedge clk);
         end
         if (i >= 8) rd[15-i] = MISO;
         SCLK = 1'b1;
         repeat (10) @(negedge clk);
      end
      if (raise_ss) begin
         SS_n = 1'b1;
         MOSI = 1'b0;
      end
   endtask

   task automatic wr(input logic [15:0] f);
      logic [7:0] d;
      spi_xfer(f, 16, 1'b1, -1, 16'h0000, d);
      repeat (8) @(negedge clk);
   endtask

   task automatic rd_chk(input string nm, input logic [7:0] addr, input logic [7:0] expv);
      logic [7:0] d;
      logic [6:0] a;
      a = addr[6:0];
      push_exp(nm, {8'h00, expv});
      spi_xfer({1'b1, a, 8'h00}, 16, 1'b1, -1, 16'h0000, d);
      repeat (8) @(negedge clk);
      observe({8'h00, d});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      smp_vld = 1'b0; yaw_in = 16'h0000;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // reset state and identity
      chk("rst_int", 16'h0, {15'h0, INT});
      chk("rst_setup", 16'h0, {15'h0, setup_done});
      chk("rst_miso", 16'h0, {15'h0, MISO});
      rd_chk("who_am_i", 8'h0F, 8'h6A);
      chk("int_after_who", 16'h0, {15'h0, INT});

      // configuration
      wr(16'h0D02);
      chk("setup_int1_only", 16'h0, {15'h0, setup_done});
      rd_chk("int1_ctrl", 8'h0D, 8'h02);
      spi_xfer(16'h1150, 16, 1'b1, -1, 16'h0000, d);
      repeat (5) @(negedge clk);
      chk("setup_done_5clk", 16'h1, {15'h0, setup_done});
      repeat (3) @(negedge clk);
      rd_chk("ctrl2_g", 8'h11, 8'h50);

      // sample and interrupt
      @(negedge clk);
      smp_vld = 1'b1; yaw_in = 16'hF3A7;
      @(negedge clk);
      smp_vld = 1'b0;
      repeat (4) @(negedge clk);
      chk("int_set", 16'h1, {15'h0, INT});
      rd_chk("outz_l", 8'h26, 8'hA7);
      chk("int_hold_after_l", 16'h1, {15'h0, INT});
      rd_chk("outz_h", 8'h27, 8'hF3);
      chk("int_clear", 16'h0, {15'h0, INT});

      // sample arriving mid-frame: old data returned, set wins over clear
      push_exp("mid_frame_outz_h", 16'h00F3);
      spi_xfer(16'hA700, 16, 1'b1, 4, 16'h1234, d);
      repeat (8) @(negedge clk);
      observe({8'h00, d});
      chk("int_set_wins", 16'h1, {15'h0, INT});
      rd_chk("new_outz_l", 8'h26, 8'h34);
      rd_chk("new_outz_h", 8'h27, 8'h12);
      chk("int_clear2", 16'h0, {15'h0, INT});

      // aborted write frame
      spi_xfer(16'h1160, 12, 1'b1, -1, 16'h0000, d);
      repeat (8) @(negedge clk);
      rd_chk("abort_ctrl2", 8'h11, 8'h50);

      // unmapped / read-only / CTRL7
      wr(16'h2055);
      rd_chk("unmapped", 8'h20, 8'h00);
      wr(16'h0F11);
      rd_chk("who_read_only", 8'h0F, 8'h6A);
      wr(16'h1533);
      rd_chk("ctrl7_g", 8'h15, 8'h33);

      // async reset in the middle of a read of CTRL2 (0x50 -> bit6 on MISO)
      spi_xfer(16'h9100, 10, 1'b0, -1, 16'h0000, d);
      chk("miso_mid_frame", 16'h1, {15'h0, MISO});
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_miso", 16'h0, {15'h0, MISO});
      chk("arst_setup", 16'h0, {15'h0, setup_done});
      chk("arst_int", 16'h0, {15'h0, INT});
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      // SS_n still low from the interrupted frame: this write must be ignored
      spi_xfer(16'h11FF, 16, 1'b1, -1, 16'h0000, d);
      repeat (8) @(negedge clk);
      chk("post_rst_setup", 16'h0, {15'h0, setup_done});
      rd_chk("post_rst_ctrl2", 8'h11, 8'h00);
      rd_chk("post_rst_int1", 8'h0D, 8'h00);
      rd_chk("post_rst_outz_h", 8'h27, 8'h00);
      rd_chk("post_rst_who", 8'h0F, 8'h6A);

      for (int k = 0; k < 50 && q.size() > 0; k++) @(negedge clk);
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
